// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit, decoder and hazard unit.
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;

  // MDOp encoding driven by the decoder
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage : md_pkg

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operands are converted to magnitudes on accept, the unsigned core runs one
// bit per cycle, and the sign of the result is restored in a single FIX cycle.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MDStart,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] MDOpX,
  input  logic [WIDTH-1:0] MDOpY,
  input  logic             MDSelHi,
  output logic [WIDTH-1:0] MDResult,
  output logic             MDBusy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   m_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   x_q;      // original dividend for divide-by-zero
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               is_div;
  logic               is_signed;
  logic               sx;
  logic               sy;
  logic               y_zero;

  logic               op_signed;
  logic [WIDTH-1:0]   x_abs;
  logic [WIDTH-1:0]   y_abs;
  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [ACC_W-1:0]   div_next;
  logic [ACC_W-1:0]   prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand conditioning: magnitudes for the signed ops
  always_comb begin
    op_signed = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    x_abs     = (op_signed && MDOpX[WIDTH-1]) ? (~MDOpX + WIDTH'(1)) : MDOpX;
    y_abs     = (op_signed && MDOpY[WIDTH-1]) ? (~MDOpY + WIDTH'(1)) : MDOpY;
  end

  // One shift-add step and one restoring shift-subtract step
  always_comb begin
    mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : (WIDTH+1)'(0));
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[ACC_W-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, m_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign restoration applied in FIX
  always_comb begin
    prod_fix = acc;
    quo_fix  = acc[WIDTH-1:0];
    rem_fix  = acc[ACC_W-1:WIDTH];
    if (is_signed && (sx ^ sy)) begin
      prod_fix = ~acc + ACC_W'(1);
      quo_fix  = ~acc[WIDTH-1:0] + WIDTH'(1);
    end
    if (is_signed && sx) begin
      rem_fix = ~acc[ACC_W-1:WIDTH] + WIDTH'(1);
    end
  end

  // Sequencer, iteration datapath and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      acc       <= '0;
      m_q       <= '0;
      x_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      y_zero    <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (MDStart) begin
            case (MDOp)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                is_div    <= (MDOp == MD_DIV) || (MDOp == MD_DIVU);
                is_signed <= op_signed;
                sx        <= op_signed & MDOpX[WIDTH-1];
                sy        <= op_signed & MDOpY[WIDTH-1];
                y_zero    <= (MDOpY == '0);
                x_q       <= MDOpX;
                cnt       <= '0;
                busy_q    <= 1'b1;
                state     <= MD_RUN;
                if ((MDOp == MD_DIV) || (MDOp == MD_DIVU)) begin
                  m_q <= y_abs;
                  acc <= {WIDTH'(0), x_abs};
                end else begin
                  m_q <= x_abs;
                  acc <= {WIDTH'(0), y_abs};
                end
              end
              MD_MTHI: hi_q <= MDOpX;
              MD_MTLO: lo_q <= MDOpX;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITERS - 1)) begin
            state <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (!is_div) begin
            hi_q <= prod_fix[ACC_W-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (y_zero) begin
            hi_q <= x_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          busy_q <= 1'b0;
          state  <= MD_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= MD_IDLE;
        end
      endcase
    end
  end

  assign MDBusy   = busy_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign MDResult = MDSelHi ? hi_q : lo_q;

endmodule : mul_div_unit

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        MDStart;
  logic [2:0]  MDOp;
  logic [31:0] MDOpX;
  logic [31:0] MDOpY;
  logic        MDSelHi;
  logic [31:0] MDResult;
  logic        MDBusy;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  mul_div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .MDStart  (MDStart),
    .MDOp     (MDOp),
    .MDOpX    (MDOpX),
    .MDOpY    (MDOpY),
    .MDSelHi  (MDSelHi),
    .MDResult (MDResult),
    .MDBusy   (MDBusy),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for exactly one accepting edge; returns at the next negedge
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    MDStart = 1'b1;
    MDOp    = op;
    MDOpX   = x;
    MDOpY   = y;
    @(negedge clk);
    MDStart = 1'b0;
    MDOp    = 3'd0;
  endtask

  // Count negedges with MDBusy high, bounded
  task automatic wait_done();
    busy_cnt = 0;
    while (MDBusy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      @(negedge clk);
    end
    chk("busy_timeout", 32'(busy_cnt < 200), 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    MDStart = 1'b0;
    MDOp    = 3'd0;
    MDOpX   = '0;
    MDOpY   = '0;
    MDSelHi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi",   Hi, 32'h0);
    chk("reset_lo",   Lo, 32'h0);
    chk("reset_busy", 32'(MDBusy), 32'h0);
    rst = 1'b0;

    // multu max*max, with busy duration
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy_rise", 32'(MDBusy), 32'h1);
    wait_done();
    chk("multu_busy_cycles", 32'(busy_cnt), 32'd33);
    chk("multu_hi", Hi, 32'hFFFFFFFE);
    chk("multu_lo", Lo, 32'h00000001);

    // mult -3 * 7
    issue(3'd1, 32'hFFFFFFFD, 32'd7);
    wait_done();
    chk("mult_hi", Hi, 32'hFFFFFFFF);
    chk("mult_lo", Lo, 32'hFFFFFFEB);

    // div -7 / 2
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done();
    chk("div_neg_lo", Lo, 32'hFFFFFFFD);
    chk("div_neg_hi", Hi, 32'hFFFFFFFF);

    // signed overflow
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    chk("div_ovf_lo", Lo, 32'h80000000);
    chk("div_ovf_hi", Hi, 32'h00000000);

    // divu by zero
    issue(3'd4, 32'd100, 32'd0);
    wait_done();
    chk("divu_zero_lo", Lo, 32'hFFFFFFFF);
    chk("divu_zero_hi", Hi, 32'd100);

    // signed div by zero keeps original dividend
    issue(3'd3, 32'hFFFFFFFB, 32'd0);
    wait_done();
    chk("div_zero_lo", Lo, 32'hFFFFFFFF);
    chk("div_zero_hi", Hi, 32'hFFFFFFFB);

    // divu plain: 1000 / 7 = 142 r 6
    issue(3'd4, 32'd1000, 32'd7);
    wait_done();
    chk("divu_lo", Lo, 32'd142);
    chk("divu_hi", Hi, 32'd6);

    // mthi then mtlo, read through MDResult
    issue(3'd5, 32'h1234, 32'h0);
    chk("mthi_no_busy", 32'(MDBusy), 32'h0);
    issue(3'd6, 32'h5678, 32'h0);
    MDSelHi = 1'b1;
    #1;
    chk("mdresult_hi", MDResult, 32'h1234);
    MDSelHi = 1'b0;
    #1;
    chk("mdresult_lo", MDResult, 32'h5678);

    // mtlo during multu is ignored; operand changes after accept ignored
    issue(3'd2, 32'd6, 32'd7);
    MDStart = 1'b1;
    MDOp    = 3'd6;
    MDOpX   = 32'hDEADBEEF;
    MDOpY   = 32'h12345678;
    @(negedge clk);
    MDStart = 1'b0;
    MDOp    = 3'd0;
    chk("busy_mtlo_lo", Lo, 32'h5678);
    chk("busy_mdresult", MDResult, 32'h5678);
    wait_done();
    chk("multu_small_lo", Lo, 32'd42);
    chk("multu_small_hi", Hi, 32'd0);

    // reset in the middle of a run
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(MDBusy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(MDBusy), 32'h0);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(3'd2, 32'd3, 32'd5);
    wait_done();
    chk("post_rst_lo", Lo, 32'd15);
    chk("post_rst_hi", Hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mul_div_unit

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative integer multiply/divide unit in the execute stage, beside the ALU. It is fed by the same ALUOpX/ALUOpY operand muxes.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers. Provides MFHI/MFLO read data to the writeback mux.
- Multi-cycle: the hazard unit stalls the pipeline while MDBusy=1.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- ITERS, WIDTH, iteration count for the shift-add and restoring loops. It must equal WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high. Clears all state immediately.
- MDStart  input  1  decoder issues MDOp this cycle.
- MDOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- MDOpX  input  WIDTH  rs operand: multiplicand / dividend / mthi-mtlo data.
- MDOpY  input  WIDTH  rt operand: multiplier / divisor.
- MDSelHi  input  1  1 selects HI onto MDResult, 0 selects LO.
- MDResult  output  WIDTH  combinational: MDSelHi ? HI : LO.
- MDBusy  output  1  operation in flight; pipeline stalls any MD instruction while high.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset:
  - State=IDLE, HI=0, LO=0, MDBusy=0, all iteration registers 0.
  - Reset mid-operation aborts the operation; no partial HI/LO write occurs.
- States: IDLE, RUN, FIX.
- IDLE:
  - MDStart & op in {1..4}: latch operands, set signed flag, clear counter, go to RUN.
    - Signed ops latch |MDOpX| and |MDOpY| and record both sign bits.
  - MDStart & op=5: HI <= MDOpX at the edge. op=6: LO <= MDOpX. No busy.
  - MDStart & op in {0,7}: no effect.
- RUN: one iteration per cycle for ITERS cycles, then go to FIX.
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on a remainder/quotient pair.
- FIX: one cycle applying the sign correction, then HI/LO are written at the closing edge and state returns to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- Timing:
  - MDBusy = (state != IDLE). It rises the cycle after the accepting edge and stays high exactly ITERS+1 = 33 cycles.
  - New HI/LO are visible the cycle MDBusy falls.
- Results:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero, signed and unsigned: LO = 32'hFFFFFFFF, HI = original MDOpX. This is forced in FIX.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- Activity while MDBusy=1:
  - MDStart is ignored for all ops, including mthi/mtlo.
  - MDResult continues to show the old HI/LO.
  - The stall is the hazard unit's job; the block never queues.
- Operands are sampled only at the accepting edge; later changes of MDOpX/MDOpY have no effect.
- All arithmetic is modulo 2^WIDTH per half; no overflow flags.

Decomposition:
- Shared package md_pkg holds:
  - MDOp encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - State enum (MD_IDLE, MD_RUN, MD_FIX).
  - MD_WIDTH=32.
- The decoder and hazard unit import the same encodings.
- No sub-module required. The sign-conditioning logic (abs/negate) may be factored into md_sign_fix, used for both operand conditioning and the FIX stage.

Test Plan:
- multu X=0xFFFFFFFF Y=0xFFFFFFFF -> MDBusy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- mult X=0xFFFFFFFD (-3) Y=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- div X=0xFFFFFFF9 (-7) Y=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- div X=0x80000000 Y=0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu X=100 Y=0 -> LO=0xFFFFFFFF, HI=100.
- Combined sequencing:
  - mthi 0x1234 then mtlo 0x5678 -> next cycle MDResult = 0x1234 (MDSelHi=1) / 0x5678 (MDSelHi=0).
  - During a multu, an mtlo start is ignored and LO is unchanged until the FIX write.
  - rst asserted at RUN cycle 10 -> MDBusy=0 and HI=LO=0 immediately; a following multu 3*5 gives LO=15.
